// File: rtl/key_schedule.sv
// AES-128 on-the-fly key expansion: one round key at a time, one 32-bit word per cycle.
// state   | meaning
// IDLE    | no key loaded, or schedule finished after round 10
// VALID   | round_key/round_num usable, waiting for advance
// COMPUTE | building the next round key into next_key, word_cnt selects the word
module key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         advance,
  output logic [127:0] round_key,
  output logic [3:0]   round_num,
  output logic         last_round,
  output logic         key_valid,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, VALID, COMPUTE} state_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  state_t       state;
  logic [1:0]   word_cnt;
  logic [127:0] next_key;
  logic [31:0]  sub_rot;
  logic [31:0]  new_word;
  logic [3:0]   rcon_idx;
  logic [7:0]   rcon;

  function automatic logic [7:0] rcon_lut(input logic [3:0] r);
    case (r)
      4'd1:    rcon_lut = 8'h01;
      4'd2:    rcon_lut = 8'h02;
      4'd3:    rcon_lut = 8'h04;
      4'd4:    rcon_lut = 8'h08;
      4'd5:    rcon_lut = 8'h10;
      4'd6:    rcon_lut = 8'h20;
      4'd7:    rcon_lut = 8'h40;
      4'd8:    rcon_lut = 8'h80;
      4'd9:    rcon_lut = 8'h1b;
      4'd10:   rcon_lut = 8'h36;
      default: rcon_lut = 8'h00;
    endcase
  endfunction

  assign rcon_idx = round_num + 4'd1;
  assign rcon     = rcon_lut(rcon_idx);

  // SubWord(RotWord(w3)): rotate left by one byte before substitution
  assign sub_rot = {SBOX[round_key[23:16]], SBOX[round_key[15:8]],
                    SBOX[round_key[7:0]],   SBOX[round_key[31:24]]};

  always_comb begin
    new_word = 32'h0;
    case (word_cnt)
      2'd0: new_word = round_key[127:96] ^ sub_rot ^ {rcon, 24'h0};
      2'd1: new_word = round_key[95:64]  ^ next_key[127:96];
      2'd2: new_word = round_key[63:32]  ^ next_key[95:64];
      2'd3: new_word = round_key[31:0]   ^ next_key[63:32];
      default: new_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      round_key  <= '0;
      round_num  <= '0;
      key_valid  <= 1'b0;
      last_round <= 1'b0;
      busy       <= 1'b0;
      word_cnt   <= '0;
      next_key   <= '0;
    end else if (start) begin
      state      <= VALID;
      round_key  <= key_in;
      round_num  <= '0;
      key_valid  <= 1'b1;
      last_round <= 1'b0;
      busy       <= 1'b0;
      word_cnt   <= '0;
    end else begin
      case (state)
        VALID: begin
          if (advance) begin
            key_valid  <= 1'b0;
            last_round <= 1'b0;
            if (round_num == 4'd10) begin
              state <= IDLE;
            end else begin
              state    <= COMPUTE;
              busy     <= 1'b1;
              word_cnt <= '0;
            end
          end
        end
        COMPUTE: begin
          case (word_cnt)
            2'd0:    next_key[127:96] <= new_word;
            2'd1:    next_key[95:64]  <= new_word;
            2'd2:    next_key[63:32]  <= new_word;
            default: next_key[31:0]   <= new_word;
          endcase
          word_cnt <= word_cnt + 2'd1;
          if (word_cnt == 2'd3) begin
            state      <= VALID;
            round_key  <= {next_key[127:32], new_word};
            round_num  <= round_num + 4'd1;
            key_valid  <= 1'b1;
            busy       <= 1'b0;
            last_round <= (round_num == 4'd9);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Bench for key_schedule: FIPS-197 vector table, corner sequences, and random traffic
// checked every cycle against a word-level key-expansion model.
module tb_key_schedule;
  logic         clk = 1'b0;
  logic         rst, start, advance;
  logic [127:0] key_in;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         last_round, key_valid, busy;

  key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .advance(advance),
    .round_key(round_key), .round_num(round_num), .last_round(last_round),
    .key_valid(key_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  typedef struct {
    logic [127:0] key;
    int           rnd;
    logic [127:0] rk;
  } vec_t;
  vec_t vt[5];

  // reference model state
  logic [7:0]   sb[256];
  logic [127:0] mk[11];
  logic [127:0] m_rk;
  int           m_rnd, m_cnt;
  bit           m_valid, m_busy;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // one clock cycle: drive inputs, advance the model, compare every output
  task automatic cyc(input logic r, input logic s, input logic a, input logic [127:0] k);
    rst = r; start = s; advance = a; key_in = k;
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_busy = 0; m_rnd = 0; m_cnt = 0; m_rk = '0;
    end else if (s) begin
      expand(k);
      m_valid = 1; m_busy = 0; m_rnd = 0; m_rk = k;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_valid = 1; m_rnd++; m_rk = mk[m_rnd];
      end
    end else if (m_valid && a) begin
      m_valid = 0;
      if (m_rnd < 10) begin
        m_busy = 1; m_cnt = 4;
      end
    end
    #1;
    chk("round_key", round_key, m_rk);
    chk("round_num", 128'(round_num), 128'(m_rnd));
    chk("key_valid", 128'(key_valid), 128'(m_valid));
    chk("busy", 128'(busy), 128'(m_busy));
    chk("last_round", 128'(last_round), 128'(m_valid && m_rnd == 10));
    rst = 0; start = 0; advance = 0;
  endtask

  task automatic run_to(input int n);
    int guard = 0;
    while (!(m_valid && m_rnd == n) && guard < 100) begin
      cyc(0, 0, 1, '0);
      guard++;
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL run_to: round %0d not reached, at %0d", n, m_rnd);
    end
  endtask

  initial begin
    vt[0] = '{K1, 0, K1};
    vt[1] = '{K1, 1, K1R1};
    vt[2] = '{K1, 10, K1RA};
    vt[3] = '{K2, 0, K2};
    vt[4] = '{K2, 1, K2R1};
    build_sbox();
    m_valid = 0; m_busy = 0; m_rnd = 0; m_cnt = 0; m_rk = '0;

    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, K1);
    chk("reset_key", round_key, '0);

    // single advance: 4 busy cycles holding round_key, then round 1
    cyc(0, 1, 0, K1);
    chk("load_k1", round_key, K1);
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0);
      chk("hold_during_compute", round_key, K1);
    end
    cyc(0, 0, 0, '0);
    chk("k1_round1", round_key, K1R1);
    chk("valid_after_4", 128'(key_valid), 128'(1));

    foreach (vt[i]) begin
      cyc(0, 1, 0, vt[i].key);
      run_to(vt[i].rnd);
      chk("vec_round_key", round_key, vt[i].rk);
      chk("vec_round_num", 128'(round_num), 128'(vt[i].rnd));
    end
    // vt[4] leaves K2 at round 1; redo K1 to round 10 and finish the schedule
    cyc(0, 1, 0, K1);
    run_to(10);
    chk("k1_last_round", 128'(last_round), 128'(1));
    cyc(0, 0, 1, '0);
    chk("done_valid", 128'(key_valid), 128'(0));
    chk("done_hold", round_key, K1RA);
    cyc(0, 0, 1, '0);

    // abort on the 2nd COMPUTE edge of round 3
    cyc(0, 1, 0, K1);
    run_to(2);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 0, K2);
    chk("abort_load", round_key, K2);
    run_to(1);
    chk("abort_round1", round_key, K2R1);

    // reset mid-compute, then advances in IDLE do nothing
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    cyc(1, 0, 0, '0);
    chk("rst_compute_key", round_key, '0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, '0);
    cyc(0, 1, 0, K1);
    chk("fresh_round", 128'(round_num), 128'(0));

    // start wins over advance at round 5
    run_to(5);
    cyc(0, 1, 1, K2);
    chk("start_over_adv", round_key, K2);
    cyc(0, 0, 0, '0);

    for (int i = 0; i < 800; i++) begin
      logic [127:0] rk;
      rk = {$urandom, $urandom, $urandom, $urandom};
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 1) == 1), rk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle pulse; loads cipher key and begins a new schedule.
REQ-005 key_in  input  128  AES-128 cipher key; sampled only on the edge where start=1; word w0 = [127:96].
REQ-006 advance  input  1  round stage requests the next round key; honoured only while key_valid=1.
REQ-007 round_key  output  128  current round key, driven directly to the round stage's round_key input.
REQ-008 round_num  output  4  index of round_key, 0..10.
REQ-009 last_round  output  1  high while key_valid=1 and round_num=10; drives the round stage's last_round input.
REQ-010 key_valid  output  1  round_key/round_num stable and usable.
REQ-011 busy  output  1  high in COMPUTE state.

Function
REQ-012 FSM states SHALL be IDLE, VALID and COMPUTE, encoded internally.
REQ-013 IDLE: key_valid=0, busy=0; start -> VALID with round_key=key_in and round_num=0 on the same edge.
REQ-014 VALID: key_valid=1; advance with round_num<10 -> COMPUTE and word counter cleared to 0.
REQ-015 VALID: advance with round_num=10 -> IDLE, key_valid=0, round_key held at the round-10 value.
REQ-016 COMPUTE SHALL generate one 32-bit word per cycle into a separate next-key register; round_key and round_num SHALL NOT change in COMPUTE.
REQ-017 Word 0 = prev_w0 XOR SubWord(RotWord(prev_w3)) XOR {Rcon[round_num+1], 24'h0}; word i (i=1..3) = prev_wi XOR new_w(i-1).
REQ-018 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1b,36 (hex).
REQ-019 SubWord SHALL use the standard AES S-box on 4 bytes, implemented combinationally inside this block.
REQ-020 After the 4th COMPUTE edge, the block SHALL enter VALID, load round_key from the next-key register and increment round_num by 1.
REQ-021 Latency: key_valid SHALL fall on the edge that accepts advance and rise again exactly 4 edges later.
REQ-022 advance while key_valid=0 SHALL be ignored.
REQ-023 start SHALL be honoured in any state, abort any computation in progress, and take priority over a simultaneous advance.
REQ-024 busy SHALL equal 1 exactly in COMPUTE; last_round SHALL equal key_valid AND (round_num==10).
REQ-025 round_num SHALL never exceed 10; a full schedule is 1 load plus 10 computations, 40 COMPUTE cycles in total.

Reset
REQ-026 While rst=1 on an edge, the block SHALL enter IDLE and clear round_key, round_num, key_valid, last_round, busy, the word counter and the next-key register to 0.
REQ-027 rst SHALL take priority over start and advance on the same edge.
REQ-028 rst asserted during COMPUTE SHALL discard the partial key; the next start SHALL begin a fresh schedule at round 0.

Verification
REQ-029 FIPS-197 key: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> next cycle key_valid=1, round_num=0, round_key=key_in.
REQ-030 One advance from round 0 -> busy=1 for 4 cycles, round_key unchanged; then round_num=1, round_key=a0fafe1788542cb123a339392a6c7605.
REQ-031 Advance held continuously -> round 10 key d014f9a8c9ee2589e13f0cc8b6630ca6 with last_round=1; next advance -> IDLE, key_valid=0.
REQ-032 start pulsed on the 2nd COMPUTE cycle of round 3 with key_in=000102030405060708090a0b0c0d0e0f -> round 0 = that key; round 1 = d6aa74fdd2af72fadaa678f1d6ab76fe.
REQ-033 rst pulsed during COMPUTE -> all outputs 0 next cycle; advance pulses while in IDLE -> no state change.
REQ-034 start and advance asserted together while in VALID at round 5 -> reload to round 0 with the new key_in; no COMPUTE entered.
